ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Sequential arbiter that shares the single-port data RAM between the instruction-fetch stage and the EX/MEM stage, which drives the ReadMem/WriteMem/DataIn controls captured by the ID/EX pipeline latch. It serializes accesses through a small FSM, applies data-first priority with a starvation bound for fetch, and returns read data with a one-cycle acknowledge. It also generates the stall signals that freeze the pipeline latches while a requester waits.

## Interface
- STARVE_LIMIT, 2, max consecutive EX grants while a fetch is pending (1..7)
- ADDR_W, 16, address width
- DATA_W, 16, data width

- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch read request, held until if_ack
- if_addr  in  ADDR_W  fetch address
- if_rdata  out  DATA_W  fetch read data, valid with if_ack
- if_ack  out  1  one-cycle fetch completion pulse
- ex_read  in  1  EX-stage ReadMem
- ex_write  in  1  EX-stage WriteMem
- ex_addr  in  ADDR_W  EX address (ALU result)
- ex_wdata  in  DATA_W  EX write data (DataIn)
- ex_rdata  out  DATA_W  EX read data, valid with ex_ack
- ex_ack  out  1  one-cycle EX completion pulse
- mem_en  out  1  RAM access strobe
- mem_we  out  1  RAM write enable
- mem_addr  out  ADDR_W  RAM address
- mem_wdata  out  DATA_W  RAM write data
- mem_rdata  in  DATA_W  RAM read data, valid when mem_ready
- mem_ready  in  1  RAM completion, may assert in first cycle of mem_en
- stall_if  out  1  freeze fetch/IF-ID latch
- stall_ex  out  1  freeze ID/EX and later latches
- err_rw  out  1  sticky: ex_read and ex_write seen high together

## Operation
- FSM states: IDLE, BUSY_IF, BUSY_EX.
- ex_req = ex_read | ex_write.
- IDLE: if ex_req and (!if_req or streak < STARVE_LIMIT) -> BUSY_EX; else if if_req -> BUSY_IF; else stay.
- On entering BUSY_x: register addr, wdata, we (we = ex_write for EX, 0 for IF); mem_en=1 from next cycle, held with stable addr/wdata/we until mem_ready.
- BUSY_x with mem_ready=1: capture mem_rdata into x_rdata, pulse x_ack next cycle, drop mem_en, return IDLE. No back-to-back grant in the ack cycle (one idle bubble per access).
- Writes: ex_ack pulsed same as reads; ex_rdata unchanged.
- streak (3 bits): +1 on each EX grant while if_req=1, saturating at 7; cleared on IF grant or when if_req=0 at grant time.
- ex_read & ex_write both 1: treated as write; err_rw set, cleared only by reset.
- Requester deasserting request mid-access: access completes, ack still pulsed, result discarded by requester.
- stall_if = if_req & !if_ack; stall_ex = ex_req & !ex_ack (combinational from registered acks and inputs).
- x_rdata holds last captured value until next read completes for that port.

## Timing
- Reset (async assert, sync release): state IDLE, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, if_ack=0, ex_ack=0, if_rdata=0, ex_rdata=0, err_rw=0, streak=0.
- Reset during BUSY: mem_en drops immediately; no ack issued for the aborted access.
- Request sampled in IDLE at edge N -> mem_en high cycle N+1; mem_ready in cycle N+1 -> ack high cycle N+2. Minimum latency 2 cycles, plus RAM wait cycles.
- Minimum spacing between grants: 3 cycles (grant, ack/bubble, IDLE decision).
- ack is exactly one cycle wide; never both acks in the same cycle.
- Simultaneous if_req and ex_req in IDLE with streak < STARVE_LIMIT: EX wins; at limit: IF wins.

## Test plan
- Single EX read addr 0x0010, RAM returns 0xBEEF with mem_ready in first mem_en cycle -> mem_en one cycle, mem_we=0, ex_ack 2 cycles after request, ex_rdata=0xBEEF, stall_ex high until ack.
- EX write addr 0x0020 data 0x1234, mem_ready delayed 3 cycles -> mem_en/mem_we/addr/wdata stable 4 cycles, ex_ack once, ex_rdata unchanged.
- if_req and ex_req held continuously, STARVE_LIMIT=2 -> grant order EX, EX, IF, EX, EX, IF; no two acks coincide.
- Only if_req, addr 0x0100, mem_rdata 0x00AA -> if_ack after 2 cycles, if_rdata=0x00AA, stall_ex=0 throughout.
- ex_read=ex_write=1 at addr 0x0030 -> write performed (mem_we=1), err_rw=1 and stays 1 after requests drop.
- rst_n low while BUSY_EX with mem_ready low -> mem_en=0 immediately, no ex_ack, all outputs at reset values; after release, new request served normally.

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between the RAM port arbiter, its two requesters and the data RAM.
// The slave modport is the arbiter's view; master is the requester/RAM side.
interface ram_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;

  logic              ex_read;
  logic              ex_write;
  logic [ADDR_W-1:0] ex_addr;
  logic [DATA_W-1:0] ex_wdata;
  logic [DATA_W-1:0] ex_rdata;
  logic              ex_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ready;

  logic              stall_if;
  logic              stall_ex;
  logic              err_rw;

  modport slave (
    input  if_req, if_addr, ex_read, ex_write, ex_addr, ex_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, ex_rdata, ex_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_ex, err_rw
  );

  modport master (
    output if_req, if_addr, ex_read, ex_write, ex_addr, ex_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, ex_rdata, ex_ack, mem_en, mem_we, mem_addr, mem_wdata,
           stall_if, stall_ex, err_rw
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Shares the single-port data RAM between instruction fetch and EX/MEM: one access
// at a time, data-first priority with a bounded EX streak so fetch cannot starve.
module ram_port_arbiter #(
  parameter int STARVE_LIMIT = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 16
) (
  input logic              clk,
  input logic              rst_n,
  ram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_EX} arbStateT;

  localparam logic [2:0] LIMIT = 3'(STARVE_LIMIT);

  arbStateT          state, nextState;
  logic [2:0]        streak;
  logic              exReq, ackPending, grantEx, grantIf;
  logic              memEn, memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memWdata;
  logic              ifAck, exAck, errRw;
  logic [DATA_W-1:0] ifRdata, exRdata;

  assign exReq      = bus.ex_read | bus.ex_write;
  // The ack cycle still shows the old request, so granting then would replay it.
  assign ackPending = ifAck | exAck;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    nextState = state;
    grantEx   = 1'b0;
    grantIf   = 1'b0;
    case (state)
      IDLE: begin
        if (!ackPending) begin
          if (exReq && (!bus.if_req || streak < LIMIT)) begin
            grantEx   = 1'b1;
            nextState = BUSY_EX;
          end else if (bus.if_req) begin
            grantIf   = 1'b1;
            nextState = BUSY_IF;
          end
        end
      end
      BUSY_IF, BUSY_EX: if (bus.mem_ready) nextState = IDLE;
      default:          nextState = IDLE;
    endcase
  end

  always_comb begin
    memEn        = (state != IDLE);
    bus.mem_en   = memEn;
    bus.mem_we   = memWe & memEn;
    bus.stall_if = bus.if_req & ~ifAck;
    bus.stall_ex = exReq & ~exAck;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking throughout so every flop samples pre-edge values.
      memWe    <= 1'b0;
      memAddr  <= '0;
      memWdata <= '0;
      ifAck    <= 1'b0;
      exAck    <= 1'b0;
      ifRdata  <= '0;
      exRdata  <= '0;
      errRw    <= 1'b0;
      streak   <= '0;
    end else begin
      ifAck <= (state == BUSY_IF) && bus.mem_ready;
      exAck <= (state == BUSY_EX) && bus.mem_ready;
      if ((state == BUSY_IF) && bus.mem_ready)
        ifRdata <= bus.mem_rdata;
      if ((state == BUSY_EX) && bus.mem_ready && !memWe)
        exRdata <= bus.mem_rdata;

      if (grantEx) begin
        memAddr  <= bus.ex_addr;
        memWdata <= bus.ex_wdata;
        memWe    <= bus.ex_write;
        if (!bus.if_req)        streak <= '0;
        else if (streak != 3'd7) streak <= streak + 3'd1;
      end else if (grantIf) begin
        memAddr  <= bus.if_addr;
        memWdata <= '0;
        memWe    <= 1'b0;
        streak   <= '0;
      end

      if (bus.ex_read && bus.ex_write) errRw <= 1'b1;
    end
  end

  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;
  assign bus.if_ack    = ifAck;
  assign bus.ex_ack    = exAck;
  assign bus.if_rdata  = ifRdata;
  assign bus.ex_rdata  = exRdata;
  assign bus.err_rw    = errRw;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a RAM responder and an ack monitor pop
// expected accesses/acks from scoreboard queues filled by the stimulus.
module tb_ram_port_arbiter;
  logic clk;
  logic rst_n;

  ram_port_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  ram_port_arbiter #(.STARVE_LIMIT(2), .ADDR_W(16), .DATA_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {bit isEx; logic [15:0] data;} ackT;
  typedef struct {bit we; logic [15:0] addr; logic [15:0] wdata;} memT;

  ackT         ackQ[$];
  memT         memQ[$];
  logic [15:0] ramImage[logic [15:0]];
  int          ramWait;
  int          nTotal = 0;
  int          nBad   = 0;
  bit          prevAck;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nTotal++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flagFail(input string msg);
    nTotal++;
    nBad++;
    $display("FAIL %s at %0t", msg, $time);
  endtask

  // RAM responder: ready after ramWait extra cycles; checks each cycle's command.
  initial begin
    int  cnt;
    memT exp;
    cnt           = 0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 16'hDEAD;
    forever begin
      @(negedge clk);
      if (bus.mem_en === 1'b1) begin
        if (memQ.size() == 0) begin
          flagFail($sformatf("mem_unexpected addr=%0h", bus.mem_addr));
        end else begin
          exp = memQ[0];
          check("mem_we", bus.mem_we, exp.we);
          check("mem_addr", bus.mem_addr, exp.addr);
          if (exp.we) check("mem_wdata", bus.mem_wdata, exp.wdata);
        end
        if (cnt == ramWait) begin
          bus.mem_ready = 1'b1;
          bus.mem_rdata = ramImage.exists(bus.mem_addr) ? ramImage[bus.mem_addr] : 16'h0000;
          if (bus.mem_we) ramImage[bus.mem_addr] = bus.mem_wdata;
          if (memQ.size() > 0) void'(memQ.pop_front());
        end else begin
          bus.mem_ready = 1'b0;
          bus.mem_rdata = 16'hDEAD;
        end
        cnt++;
      end else begin
        cnt           = 0;
        bus.mem_ready = 1'b0;
        bus.mem_rdata = 16'hDEAD;
      end
    end
  end

  // Ack monitor: every ack must match the next scoreboard entry.
  initial begin
    ackT a;
    prevAck = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && (bus.if_ack || bus.ex_ack)) begin
        check("ack_overlap", bus.if_ack & bus.ex_ack, 0);
        check("ack_width", prevAck, 0);
        if (ackQ.size() == 0) begin
          flagFail($sformatf("ack_unexpected if_ack=%0b ex_ack=%0b", bus.if_ack, bus.ex_ack));
        end else begin
          a = ackQ.pop_front();
          check("ack_port", bus.ex_ack, a.isEx);
          check(a.isEx ? "ex_rdata" : "if_rdata", a.isEx ? bus.ex_rdata : bus.if_rdata, a.data);
        end
      end
      prevAck = bus.if_ack | bus.ex_ack;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Waits for one ack; with expLat > 0 also checks stalls and latency in cycles.
  task automatic waitAck(input bit isEx, input int expLat);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(negedge clk);
      n++;
      seen = isEx ? bus.ex_ack : bus.if_ack;
      if (expLat > 0) begin
        if (isEx) begin
          check("stall_ex", bus.stall_ex, n < expLat);
        end else begin
          check("stall_if", bus.stall_if, n < expLat);
          check("stall_ex_idle", bus.stall_ex, 0);
        end
      end
    end
    if (!seen) flagFail(isEx ? "ex_ack_timeout" : "if_ack_timeout");
    else if (expLat > 0) check("ack_latency", n, expLat);
  endtask

  task automatic doEx(input logic rd, input logic wr, input logic [15:0] addr,
                      input logic [15:0] wd, input int expLat);
    @(posedge clk); #1;
    bus.ex_read  = rd;
    bus.ex_write = wr;
    bus.ex_addr  = addr;
    bus.ex_wdata = wd;
    waitAck(1'b1, expLat);
    @(posedge clk); #1;
    bus.ex_read  = 1'b0;
    bus.ex_write = 1'b0;
  endtask

  task automatic doIf(input logic [15:0] addr, input int expLat);
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = addr;
    waitAck(1'b0, expLat);
    @(posedge clk); #1;
    bus.if_req = 1'b0;
  endtask

  task automatic exStream();
    @(posedge clk); #1;
    bus.ex_read = 1'b1;
    bus.ex_addr = 16'h0200;
    for (int i = 1; i <= 4; i++) begin
      waitAck(1'b1, 0);
      @(posedge clk); #1;
      bus.ex_addr = 16'h0200 + 16'(i);
    end
    bus.ex_read = 1'b0;
  endtask

  task automatic ifStream();
    @(posedge clk); #1;
    bus.if_req  = 1'b1;
    bus.if_addr = 16'h0300;
    for (int i = 1; i <= 2; i++) begin
      waitAck(1'b0, 0);
      @(posedge clk); #1;
      bus.if_addr = 16'h0300 + 16'(i);
    end
    bus.if_req = 1'b0;
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.if_req   = 1'b0;
    bus.if_addr  = '0;
    bus.ex_read  = 1'b0;
    bus.ex_write = 1'b0;
    bus.ex_addr  = '0;
    bus.ex_wdata = '0;
    ramWait      = 0;
    ramImage[16'h0010] = 16'hBEEF;
    ramImage[16'h0100] = 16'h00AA;
    ramImage[16'h0200] = 16'hE000;
    ramImage[16'h0201] = 16'hE001;
    ramImage[16'h0202] = 16'hE002;
    ramImage[16'h0203] = 16'hE003;
    ramImage[16'h0300] = 16'hF000;
    ramImage[16'h0301] = 16'hF001;

    repeat (2) @(negedge clk);
    check("rst_mem_en", bus.mem_en, 0);
    check("rst_mem_we", bus.mem_we, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_if_ack", bus.if_ack, 0);
    check("rst_ex_ack", bus.ex_ack, 0);
    check("rst_if_rdata", bus.if_rdata, 0);
    check("rst_ex_rdata", bus.ex_rdata, 0);
    check("rst_err_rw", bus.err_rw, 0);
    check("rst_stall_if", bus.stall_if, 0);
    check("rst_stall_ex", bus.stall_ex, 0);
    rst_n = 1'b1;

    // Single EX read, RAM ready in the first mem_en cycle.
    ramWait = 0;
    memQ.push_back('{1'b0, 16'h0010, 16'h0000});
    ackQ.push_back('{1'b1, 16'hBEEF});
    doEx(1'b1, 1'b0, 16'h0010, 16'h0000, 3);

    // EX write with three RAM wait cycles; ex_rdata keeps the last read value.
    ramWait = 3;
    memQ.push_back('{1'b1, 16'h0020, 16'h1234});
    ackQ.push_back('{1'b1, 16'hBEEF});
    doEx(1'b0, 1'b1, 16'h0020, 16'h1234, 6);

    // Fetch alone.
    ramWait = 0;
    memQ.push_back('{1'b0, 16'h0100, 16'h0000});
    ackQ.push_back('{0, 16'h00AA});
    doIf(16'h0100, 3);

    // Read and write together: performed as a write, sticky error flag.
    check("err_rw_before", bus.err_rw, 0);
    memQ.push_back('{1'b1, 16'h0030, 16'h5555});
    ackQ.push_back('{1'b1, 16'hBEEF});
    doEx(1'b1, 1'b1, 16'h0030, 16'h5555, 3);
    repeat (2) @(negedge clk);
    check("err_rw_sticky", bus.err_rw, 1);

    // Both requesters held: expected grant order EX EX IF EX EX IF.
    ramWait = 1;
    memQ.push_back('{1'b0, 16'h0200, 16'h0000}); ackQ.push_back('{1'b1, 16'hE000});
    memQ.push_back('{1'b0, 16'h0201, 16'h0000}); ackQ.push_back('{1'b1, 16'hE001});
    memQ.push_back('{1'b0, 16'h0300, 16'h0000}); ackQ.push_back('{1'b0, 16'hF000});
    memQ.push_back('{1'b0, 16'h0202, 16'h0000}); ackQ.push_back('{1'b1, 16'hE002});
    memQ.push_back('{1'b0, 16'h0203, 16'h0000}); ackQ.push_back('{1'b1, 16'hE003});
    memQ.push_back('{1'b0, 16'h0301, 16'h0000}); ackQ.push_back('{1'b0, 16'hF001});
    fork
      exStream();
      ifStream();
    join
    repeat (3) @(negedge clk);
    check("arb_queue_drained", ackQ.size(), 0);
    check("err_rw_still", bus.err_rw, 1);

    // Reset while an EX access waits on the RAM: abort without ack.
    ramWait = 10;
    memQ.push_back('{1'b0, 16'h0040, 16'h0000});
    @(posedge clk); #1;
    bus.ex_read = 1'b1;
    bus.ex_addr = 16'h0040;
    repeat (3) @(negedge clk);
    check("busy_mem_en", bus.mem_en, 1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_mem_en", bus.mem_en, 0);
    check("abort_mem_we", bus.mem_we, 0);
    check("abort_mem_addr", bus.mem_addr, 0);
    check("abort_ex_ack", bus.ex_ack, 0);
    check("abort_ex_rdata", bus.ex_rdata, 0);
    check("abort_if_rdata", bus.if_rdata, 0);
    check("abort_err_rw", bus.err_rw, 0);
    bus.ex_read = 1'b0;
    memQ.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_abort_ex_ack", bus.ex_ack, 0);

    ramWait = 0;
    memQ.push_back('{1'b0, 16'h0010, 16'h0000});
    ackQ.push_back('{1'b1, 16'hBEEF});
    doEx(1'b1, 1'b0, 16'h0010, 16'h0000, 3);

    repeat (4) @(negedge clk);
    check("ackQ_left", ackQ.size(), 0);
    check("memQ_left", memQ.size(), 0);
    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end
endmodule
